load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Multi-cycle load/store unit directly downstream of the ALU. It takes the ALU result as the effective address and rs2 as store data. It drives a request/acknowledge data-memory bus with byte enables and returns aligned, sign- or zero-extended load data to the writeback mux. It stalls the core while a bus transaction is outstanding.

Parameters:
TIMEOUT_CYCLES, 16, wait cycles in REQ before the access is aborted with a bus error.
CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clk_i  in  1  single clock, rising edge
rst_i  in  1  asynchronous, active-high reset
mem_rd_i  in  1  load request (from decode)
mem_wr_i  in  1  store request (from decode)
funct3_i  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
addr_i  in  32  effective address (ALU Result_o)
wdata_i  in  32  store data (rs2)
busy_o  out  1  stall core
done_o  out  1  one-cycle completion pulse
rdata_o  out  32  extended load data, valid while done_o=1
err_o  out  2  00 none, 01 misaligned, 10 illegal funct3, 11 bus timeout; valid with done_o
dmem_req_o  out  1  bus request
dmem_we_o  out  1  1 = write
dmem_addr_o  out  32  word-aligned address, {addr[31:2],2'b00}
dmem_be_o  out  4  byte enables
dmem_wdata_o  out  32  lane-replicated store data
dmem_rdata_i  in  32  read word
dmem_ack_i  in  1  bus acknowledge

Behaviour:
- Clocking and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values: state=IDLE, all outputs 0, counter 0, latched address/data/funct3 0.
- Reset mid-transaction drops dmem_req_o immediately. No done_o is produced.
- A request is any of mem_rd_i or mem_wr_i. If both are set, store wins.
- States: IDLE, REQ, DONE.
- IDLE, no request: stay in IDLE, busy_o=0.
- IDLE, request, legal and aligned: latch addr, wdata, funct3 and we, then go to REQ.
- IDLE, request, illegal or misaligned: set err_o, go to DONE, no bus access.
- Illegal funct3: store with funct3 not in {000,001,010}, or load with funct3 in {011,110,111}.
- Misaligned: half access with addr[0]=1, or word access with addr[1:0]≠00. Misalignment is checked before illegal-funct3; only legal funct3 are checked for alignment.
- REQ: dmem_req_o=1 with stable addr/we/be/wdata until acknowledged. The counter increments every cycle without ack.
- REQ, dmem_ack_i=1 (may arrive in the first REQ cycle): capture dmem_rdata_i, go to DONE with err_o=00.
- REQ, counter reaches TIMEOUT_CYCLES without ack: deassert dmem_req_o, go to DONE with err_o=11 and rdata_o=0. An ack arriving in the same cycle wins over the timeout.
- DONE: done_o=1 for exactly one cycle, then return to IDLE. Requests are ignored in DONE; the core drops its request on done_o.
- busy_o = (state==REQ) | (state==IDLE & request). It is combinational so a single-cycle core stalls in the request cycle. busy_o=0 in DONE.
- Minimum latency, legal access with immediate ack: request cycle, then REQ (ack), then DONE. This is 2 cycles from request to done_o.
- Store lanes:
  - SB: be = 0001<<addr[1:0], wdata = {4{rs2[7:0]}}.
  - SH: be = 0011<<addr[1:0], wdata = {2{rs2[15:0]}}.
  - SW: be = 1111.
  - Loads drive be=1111, we=0.
- Load extension on the captured word:
  - Byte lane selected by addr[1:0]; half selected by addr[1].
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
  - rdata_o is held at 0 outside DONE and for stores.
- rdata_o and err_o are registered on the transition into DONE.

Decomposition:
- Shared defines file holds:
  - funct3 size codes (LS_B, LS_H, LS_W, LS_BU, LS_HU),
  - the state enum (IDLE/REQ/DONE),
  - error codes (ERR_NONE, ERR_MISALIGN, ERR_ILLEGAL, ERR_TIMEOUT).
- One combinational sub-module, load_extend (inputs: word, addr[1:0], funct3; output: 32-bit extended data), reused by writeback tests.
- Store lane/byte-enable generation stays inline.

Test Plan:
1. SW addr=0x0000_1008, rs2=0xDEAD_BEEF, ack in first REQ cycle -> dmem_addr=0x1008, be=1111, wdata=0xDEADBEEF, we=1; done_o 2 cycles after request, err=00.
2. LB addr=0x0000_2003, memory word 0x80FF_7F01, ack after 3 waits -> be=1111, we=0; rdata_o=0xFFFF_FF80, done_o on cycle 5; repeat with LBU -> 0x0000_0080.
3. SH addr=0x0000_3002, rs2=0x1234_ABCD -> be=1100, wdata=0xABCD_ABCD; LHU same address with word 0xABCD_0000 -> rdata_o=0x0000_ABCD.
4. LW addr=0x0000_4002 -> no dmem_req_o ever; done_o next cycle with err=01. SB with funct3=100 -> err=10, no bus access.
5. LW with ack never asserted, TIMEOUT_CYCLES=16 -> dmem_req_o high 16 cycles then low; done_o with err=11, rdata_o=0. Ack on cycle 16 instead -> err=00, data captured.
6. Assert rst_i mid-REQ (cycle 2 of 5 waits) -> dmem_req_o, busy_o, done_o go 0 asynchronously; after release, a new SW completes normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// ============================================================================
// Module : load_store_unit_pkg
// Brief  : Shared access-size codes, FSM states and error codes for the LSU.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package load_store_unit_pkg;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

endpackage

`default_nettype wire

// File: rtl/load_store_unit_if.sv
// ============================================================================
// Module : load_store_unit_if
// Brief  : Core-side request and data-memory bus bundle of the load/store unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface load_store_unit_if;
    logic        mem_rd_i;
    logic        mem_wr_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic [1:0]  err_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic [31:0] dmem_rdata_i;
    logic        dmem_ack_i;

    modport slave (
        input  mem_rd_i, mem_wr_i, funct3_i, addr_i, wdata_i, dmem_rdata_i, dmem_ack_i,
        output busy_o, done_o, rdata_o, err_o,
        output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o
    );

    modport master (
        output mem_rd_i, mem_wr_i, funct3_i, addr_i, wdata_i, dmem_rdata_i, dmem_ack_i,
        input  busy_o, done_o, rdata_o, err_o,
        input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o
    );
endinterface

`default_nettype wire

// File: rtl/load_store_unit_load_extend.sv
// ============================================================================
// Module : load_extend
// Brief  : Selects the addressed byte/half of a read word and extends it.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module load_extend
    import load_store_unit_pkg::*;
(
    input  wire logic [31:0] i_word,
    input  wire logic [1:0]  i_addr,
    input  wire logic [2:0]  i_funct3,
    output logic      [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[{i_addr, 3'b000} +: 8];
        w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];
        case (i_funct3)
            LS_B:    o_data = {{24{w_byte[7]}}, w_byte};
            LS_BU:   o_data = {24'd0, w_byte};
            LS_H:    o_data = {{16{w_half[15]}}, w_half};
            LS_HU:   o_data = {16'd0, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module : load_store_unit
// Brief  : Multi-cycle load/store unit with req/ack data bus and timeout.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  wire logic         clk_i,
    input  wire logic         rst_i,
    load_store_unit_if.slave  lsu
);

    lsu_state_t        r_state;
    lsu_state_t        w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic [2:0]        r_funct3;
    logic              r_we;
    logic [31:0]       r_rdata;
    logic [1:0]        r_err;

    logic              w_req;
    logic              w_illegal;
    logic              w_misalign;
    logic [1:0]        w_pre_err;
    logic              w_timeout;
    logic [31:0]       w_ext;

    assign w_req = lsu.mem_rd_i | lsu.mem_wr_i;

    // Store wins when both are set, so legality is judged against the store rules.
    always_comb begin
        if (lsu.mem_wr_i)
            w_illegal = !(lsu.funct3_i inside {LS_B, LS_H, LS_W});
        else
            w_illegal = lsu.funct3_i inside {3'b011, 3'b110, 3'b111};
        w_misalign = !w_illegal &&
                     ((lsu.funct3_i[1:0] == 2'b01 && lsu.addr_i[0]) ||
                      (lsu.funct3_i[1:0] == 2'b10 && lsu.addr_i[1:0] != 2'b00));
        w_pre_err  = w_misalign ? ERR_MISALIGN : (w_illegal ? ERR_ILLEGAL : ERR_NONE);
    end

    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) && !lsu.dmem_ack_i;

    load_extend u_load_extend (
        .i_word   (lsu.dmem_rdata_i),
        .i_addr   (r_addr[1:0]),
        .i_funct3 (r_funct3),
        .o_data   (w_ext)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_req) w_next = (w_pre_err != ERR_NONE) ? DONE : REQ;
            REQ:     if (lsu.dmem_ack_i || w_timeout) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt    <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_funct3 <= '0;
            r_we     <= 1'b0;
            r_rdata  <= '0;
            r_err    <= ERR_NONE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req && w_pre_err == ERR_NONE) begin
                        r_addr   <= lsu.addr_i;
                        r_wdata  <= lsu.wdata_i;
                        r_funct3 <= lsu.funct3_i;
                        r_we     <= lsu.mem_wr_i;
                        r_cnt    <= '0;
                    end else if (w_req) begin
                        r_err    <= w_pre_err;
                        r_rdata  <= '0;
                    end
                end
                REQ: begin
                    if (lsu.dmem_ack_i) begin
                        r_err   <= ERR_NONE;
                        r_rdata <= r_we ? 32'd0 : w_ext;
                    end else if (w_timeout) begin
                        r_err   <= ERR_TIMEOUT;
                        r_rdata <= '0;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_err   <= ERR_NONE;
                    r_rdata <= '0;
                end
            endcase
        end
    end

    // Bus fields read as zero outside REQ so an idle bus is fully quiet.
    always_comb begin
        lsu.busy_o       = (r_state == REQ) || (r_state == IDLE && w_req);
        lsu.done_o       = (r_state == DONE);
        lsu.rdata_o      = r_rdata;
        lsu.err_o        = r_err;
        lsu.dmem_req_o   = 1'b0;
        lsu.dmem_we_o    = 1'b0;
        lsu.dmem_addr_o  = '0;
        lsu.dmem_be_o    = '0;
        lsu.dmem_wdata_o = '0;
        if (r_state == REQ) begin
            lsu.dmem_req_o  = 1'b1;
            lsu.dmem_we_o   = r_we;
            lsu.dmem_addr_o = {r_addr[31:2], 2'b00};
            if (!r_we) begin
                lsu.dmem_be_o    = 4'b1111;
                lsu.dmem_wdata_o = r_wdata;
            end else begin
                case (r_funct3[1:0])
                    2'b00: begin
                        lsu.dmem_be_o    = 4'b0001 << r_addr[1:0];
                        lsu.dmem_wdata_o = {4{r_wdata[7:0]}};
                    end
                    2'b01: begin
                        lsu.dmem_be_o    = 4'b0011 << r_addr[1:0];
                        lsu.dmem_wdata_o = {2{r_wdata[15:0]}};
                    end
                    default: begin
                        lsu.dmem_be_o    = 4'b1111;
                        lsu.dmem_wdata_o = r_wdata;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module : tb_load_store_unit
// Brief  : Directed self-checking bench with a transaction-level LSU model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_load_store_unit;
    import load_store_unit_pkg::*;

    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    load_store_unit_if bus ();

    load_store_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .lsu   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Expected transaction, filled by the model.
    bit          active = 1'b0;
    int          cyc = 0;
    int          done_at = 0;
    logic [1:0]  x_err;
    logic [31:0] x_rdata, x_addr, x_wd;
    logic [3:0]  x_be;
    bit          x_we;

    logic [31:0] last_rdata, last_wd;
    logic [1:0]  last_err;
    logic [3:0]  last_be;
    int          last_done, req_cycles;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Outcome of one access derived from the architectural rules.
    task automatic model(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] word, input int w);
        bit legal, mis, store;
        int b, h;
        logic [31:0] ld;
        store = wr;
        legal = store ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        mis   = legal && ((f3[1:0] == 2'd1 && a[0]) || (f3[1:0] == 2'd2 && a[1:0] != 2'd0));
        b = int'((word >> (8 * a[1:0])) & 32'hFF);
        h = int'(a[1] ? word[31:16] : word[15:0]);
        case (f3)
            3'd0:    ld = 32'((b >= 128) ? b - 256 : b);
            3'd4:    ld = 32'(b);
            3'd1:    ld = 32'((h >= 32768) ? h - 65536 : h);
            3'd5:    ld = 32'(h);
            default: ld = word;
        endcase
        x_we   = store;
        x_addr = a & 32'hFFFF_FFFC;
        if (!store)                x_be = 4'hF;
        else if (f3 == 3'd0)       x_be = 4'(1 << a[1:0]);
        else if (f3 == 3'd1)       x_be = 4'(3 << a[1:0]);
        else                       x_be = 4'hF;
        if (f3 == 3'd0)            x_wd = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
        else if (f3 == 3'd1)       x_wd = {wd[15:0], wd[15:0]};
        else                       x_wd = wd;
        if (mis)                   begin x_err = 2'b01; done_at = 1; end
        else if (!legal)           begin x_err = 2'b10; done_at = 1; end
        else if (w >= TO)          begin x_err = 2'b11; done_at = TO + 1; end
        else                       begin x_err = 2'b00; done_at = w + 2; end
        x_rdata = (x_err != 2'b00 || store || !rd) ? 32'd0 : ld;
    endtask

    always @(negedge clk) begin
        if (bus.dmem_req_o) req_cycles++;
        if (bus.done_o) last_done = cyc;
        if (!active || rst || cyc > done_at) begin
            chk("idle busy", bus.busy_o, 1'b0);
            chk("idle done", bus.done_o, 1'b0);
            chk("idle req", bus.dmem_req_o, 1'b0);
            chk("idle rdata", bus.rdata_o, 32'd0);
            chk("idle err", bus.err_o, 2'b00);
        end else if (cyc == 0) begin
            chk("reqcyc busy", bus.busy_o, 1'b1);
            chk("reqcyc req", bus.dmem_req_o, 1'b0);
            chk("reqcyc done", bus.done_o, 1'b0);
        end else if (cyc < done_at) begin
            chk("bus req", bus.dmem_req_o, 1'b1);
            chk("bus busy", bus.busy_o, 1'b1);
            chk("bus done", bus.done_o, 1'b0);
            chk("bus addr", bus.dmem_addr_o, x_addr);
            chk("bus we", bus.dmem_we_o, x_we);
            chk("bus be", bus.dmem_be_o, x_be);
            if (x_we) chk("bus wdata", bus.dmem_wdata_o, x_wd);
            last_be = bus.dmem_be_o;
            last_wd = bus.dmem_wdata_o;
        end else begin
            chk("done pulse", bus.done_o, 1'b1);
            chk("done busy", bus.busy_o, 1'b0);
            chk("done req", bus.dmem_req_o, 1'b0);
            chk("done err", bus.err_o, x_err);
            chk("done rdata", bus.rdata_o, x_rdata);
            last_rdata = bus.rdata_o;
            last_err   = bus.err_o;
        end
    end

    task automatic start(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] word, input int w);
        @(posedge clk); #1;
        model(rd, wr, f3, a, wd, word, w);
        bus.mem_rd_i     = rd;
        bus.mem_wr_i     = wr;
        bus.funct3_i     = f3;
        bus.addr_i       = a;
        bus.wdata_i      = wd;
        bus.dmem_rdata_i = word;
        bus.dmem_ack_i   = 1'b0;
        req_cycles = 0;
        last_done  = -1;
        cyc    = 0;
        active = 1'b1;
    endtask

    task automatic step(input int w);
        @(posedge clk); #1;
        cyc++;
        bus.dmem_ack_i = (w < TO) && (cyc == w + 1);
        if (cyc == done_at) begin
            bus.mem_rd_i = 1'b0;
            bus.mem_wr_i = 1'b0;
        end
    endtask

    task automatic run(input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] word, input int w);
        start(rd, wr, f3, a, wd, word, w);
        while (cyc < done_at + 1) step(w);
    endtask

    initial begin
        bus.mem_rd_i = 1'b0; bus.mem_wr_i = 1'b0; bus.funct3_i = '0;
        bus.addr_i = '0; bus.wdata_i = '0; bus.dmem_rdata_i = '0; bus.dmem_ack_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        run(0, 1, LS_W, 32'h0000_1008, 32'hDEAD_BEEF, 32'h0, 0);
        chk("T1 be", last_be, 4'b1111);
        chk("T1 wdata", last_wd, 32'hDEAD_BEEF);
        chk("T1 latency", last_done, 2);

        run(1, 0, LS_B, 32'h0000_2003, 32'h0, 32'h80FF_7F01, 3);
        chk("T2 LB rdata", last_rdata, 32'hFFFF_FF80);
        chk("T2 latency", last_done, 5);
        run(1, 0, LS_BU, 32'h0000_2003, 32'h0, 32'h80FF_7F01, 3);
        chk("T2 LBU rdata", last_rdata, 32'h0000_0080);
        run(1, 0, LS_B, 32'h0000_2001, 32'h0, 32'h80FF_7F01, 1);
        chk("LB lane1", last_rdata, 32'h0000_007F);

        run(0, 1, LS_H, 32'h0000_3002, 32'h1234_ABCD, 32'h0, 1);
        chk("T3 SH be", last_be, 4'b1100);
        chk("T3 SH wdata", last_wd, 32'hABCD_ABCD);
        run(1, 0, LS_HU, 32'h0000_3002, 32'h0, 32'hABCD_0000, 0);
        chk("T3 LHU rdata", last_rdata, 32'h0000_ABCD);
        run(1, 0, LS_H, 32'h0000_3002, 32'h0, 32'hABCD_0000, 2);
        chk("LH rdata", last_rdata, 32'hFFFF_ABCD);
        run(1, 1, LS_B, 32'h0000_3001, 32'h0000_005A, 32'h0, 0);
        chk("SB both be", last_be, 4'b0010);
        chk("SB both wdata", last_wd, 32'h5A5A_5A5A);

        run(1, 0, LS_W, 32'h0000_4002, 32'h0, 32'h0, 0);
        chk("T4 misalign err", last_err, 2'b01);
        chk("T4 no bus", req_cycles, 0);
        chk("T4 latency", last_done, 1);
        run(0, 1, LS_BU, 32'h0000_4000, 32'h0, 32'h0, 0);
        chk("T4 illegal err", last_err, 2'b10);
        chk("T4 illegal no bus", req_cycles, 0);
        run(1, 0, 3'b011, 32'h0000_4001, 32'h0, 32'h0, 0);
        chk("illegal load err", last_err, 2'b10);

        run(1, 0, LS_W, 32'h0000_5000, 32'h0, 32'h1111_2222, 99);
        chk("T5 timeout err", last_err, 2'b11);
        chk("T5 timeout rdata", last_rdata, 32'h0);
        chk("T5 req cycles", req_cycles, 16);
        run(1, 0, LS_W, 32'h0000_5000, 32'h0, 32'h1111_2222, 15);
        chk("T5 late ack err", last_err, 2'b00);
        chk("T5 late ack rdata", last_rdata, 32'h1111_2222);

        start(1, 0, LS_W, 32'h0000_6000, 32'h0, 32'h0, 5);
        while (cyc < 2) step(5);
        #1;
        chk("T6 pre-reset req", bus.dmem_req_o, 1'b1);
        rst = 1'b1;
        bus.mem_rd_i = 1'b0;
        active = 1'b0;
        #1;
        chk("T6 async req", bus.dmem_req_o, 1'b0);
        chk("T6 async busy", bus.busy_o, 1'b0);
        chk("T6 async done", bus.done_o, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run(0, 1, LS_W, 32'h0000_7004, 32'hCAFE_F00D, 32'h0, 1);
        chk("T6 after reset wdata", last_wd, 32'hCAFE_F00D);
        chk("T6 after reset err", last_err, 2'b00);

        @(posedge clk); #1;
        active = 1'b0;
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
